// File: rtl/wgt_load_sequencer.sv
// Weight-load sequencer: takes one layer config, checks it, sizes the weight
// transfer, runs one DMA request and one buffer load, then steps the weight
// buffer through one read pass per (IC tile, 2-bit slice), counting MAC beats.
module wgt_load_sequencer #(
  parameter int IC2_LANES  = 16,
  parameter int OC2_LANES  = 16,
  parameter int WBUF_BYTES = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] cfg_oc,
  input  logic [15:0] cfg_ic,
  input  logic [7:0]  cfg_kh,
  input  logic [7:0]  cfg_kw,
  input  logic [7:0]  cfg_wgt_bits,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        dma_req_valid,
  input  logic        dma_req_ready,
  output logic [31:0] dma_req_bytes,
  output logic        wb_load_start,
  output logic [31:0] wb_wgt_bytes,
  input  logic        wb_load_done,
  output logic        wb_read_start,
  output logic [2:0]  wb_slice_sel,
  output logic [15:0] wb_ic_tile,
  input  logic        rd_valid,
  input  logic        rd_ready
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CALC,
    S_ERR,
    S_DMA_REQ,
    S_LOAD_WAIT,
    S_PASS_START,
    S_READ,
    S_NEXT,
    S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] oc_reg, oc_next;
  logic [15:0] ic_reg, ic_next;
  logic [7:0]  kh_reg, kh_next;
  logic [7:0]  kw_reg, kw_next;
  logic [7:0]  bits_reg, bits_next;
  logic [31:0] bytes_reg, bytes_next;
  logic [3:0]  slices_reg, slices_next;
  logic [31:0] beats_reg, beats_next;
  logic [31:0] beat_cnt_reg, beat_cnt_next;
  logic [2:0]  slice_reg, slice_next;
  logic [15:0] ic_tile_reg, ic_tile_next;

  // Layer sizing from the latched config. The product is kept 64 bits wide so
  // an oversized layer can never wrap into an apparently small byte count.
  logic [63:0] calc_bits_total;
  logic [63:0] calc_bytes;
  logic [16:0] oc_groups;
  logic [31:0] calc_beats;
  logic        dims_ok;
  logic        bits_ok;
  logic        cfg_ok;
  logic        last_slice;
  logic        last_tile;
  logic        beat_fire;

  assign calc_bits_total = 64'(kh_reg) * 64'(kw_reg) * 64'(oc_reg) * 64'(ic_reg) * 64'(bits_reg);
  assign calc_bytes      = (calc_bits_total + 64'd7) >> 3;
  assign oc_groups       = ({1'b0, oc_reg} + 17'(OC2_LANES - 1)) / 17'(OC2_LANES);
  assign calc_beats      = 32'(kh_reg) * 32'(kw_reg) * 32'(oc_groups);
  assign dims_ok         = (oc_reg != 16'd0) && (ic_reg != 16'd0) && (kh_reg != 8'd0) && (kw_reg != 8'd0);
  assign bits_ok         = (bits_reg == 8'd2) || (bits_reg == 8'd4) || (bits_reg == 8'd8) || (bits_reg == 8'd16);
  assign cfg_ok          = dims_ok && bits_ok && (calc_bytes <= 64'(WBUF_BYTES));

  // A pass is the final one when it used the top slice of the tile that
  // covers the highest input channel.
  assign last_slice = (4'(slice_reg) + 4'd1) >= slices_reg;
  assign last_tile  = ({1'b0, ic_tile_reg} + 17'(IC2_LANES)) >= {1'b0, ic_reg};
  assign beat_fire  = rd_valid && rd_ready;

  assign busy          = (state_reg != S_IDLE);
  assign done          = (state_reg == S_DONE);
  assign err           = (state_reg == S_ERR);
  assign dma_req_valid = (state_reg == S_DMA_REQ);
  assign dma_req_bytes = bytes_reg;
  assign wb_wgt_bytes  = bytes_reg;
  assign wb_load_start = (state_reg == S_DMA_REQ) && dma_req_ready;
  assign wb_read_start = (state_reg == S_PASS_START);
  assign wb_slice_sel  = slice_reg;
  assign wb_ic_tile    = ic_tile_reg;

  // Next-state and datapath updates for every sequencer state.
  always_comb begin
    state_next    = state_reg;
    oc_next       = oc_reg;
    ic_next       = ic_reg;
    kh_next       = kh_reg;
    kw_next       = kw_reg;
    bits_next     = bits_reg;
    bytes_next    = bytes_reg;
    slices_next   = slices_reg;
    beats_next    = beats_reg;
    beat_cnt_next = beat_cnt_reg;
    slice_next    = slice_reg;
    ic_tile_next  = ic_tile_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          oc_next    = cfg_oc;
          ic_next    = cfg_ic;
          kh_next    = cfg_kh;
          kw_next    = cfg_kw;
          bits_next  = cfg_wgt_bits;
          state_next = S_CALC;
        end
      end
      S_CALC: begin
        if (!cfg_ok) begin
          state_next = S_ERR;
        end else begin
          bytes_next  = calc_bytes[31:0];
          slices_next = 4'(bits_reg >> 1);
          beats_next  = calc_beats;
          state_next  = S_DMA_REQ;
        end
      end
      S_ERR: begin
        state_next = S_IDLE;
      end
      S_DMA_REQ: begin
        if (dma_req_ready) begin
          state_next = S_LOAD_WAIT;
        end
      end
      S_LOAD_WAIT: begin
        if (wb_load_done) begin
          slice_next   = 3'd0;
          ic_tile_next = 16'd0;
          state_next   = S_PASS_START;
        end
      end
      S_PASS_START: begin
        beat_cnt_next = 32'd0;
        state_next    = S_READ;
      end
      S_READ: begin
        if (beat_fire) begin
          beat_cnt_next = beat_cnt_reg + 32'd1;
          if (beat_cnt_next == beats_reg) begin
            state_next = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (last_slice && last_tile) begin
          // Park the selects at zero as the layer ends.
          slice_next   = 3'd0;
          ic_tile_next = 16'd0;
          state_next   = S_DONE;
        end else begin
          if (!last_slice) begin
            slice_next = slice_reg + 3'd1;
          end else begin
            slice_next   = 3'd0;
            ic_tile_next = ic_tile_reg + 16'(IC2_LANES);
          end
          state_next = S_PASS_START;
        end
      end
      S_DONE: begin
        bytes_next    = 32'd0;
        beats_next    = 32'd0;
        slices_next   = 4'd0;
        beat_cnt_next = 32'd0;
        state_next    = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any layer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      oc_reg       <= 16'd0;
      ic_reg       <= 16'd0;
      kh_reg       <= 8'd0;
      kw_reg       <= 8'd0;
      bits_reg     <= 8'd0;
      bytes_reg    <= 32'd0;
      slices_reg   <= 4'd0;
      beats_reg    <= 32'd0;
      beat_cnt_reg <= 32'd0;
      slice_reg    <= 3'd0;
      ic_tile_reg  <= 16'd0;
    end else begin
      state_reg    <= state_next;
      oc_reg       <= oc_next;
      ic_reg       <= ic_next;
      kh_reg       <= kh_next;
      kw_reg       <= kw_next;
      bits_reg     <= bits_next;
      bytes_reg    <= bytes_next;
      slices_reg   <= slices_next;
      beats_reg    <= beats_next;
      beat_cnt_reg <= beat_cnt_next;
      slice_reg    <= slice_next;
      ic_tile_reg  <= ic_tile_next;
    end
  end

endmodule

// File: tb/tb_wgt_load_sequencer.sv
// Bench for wgt_load_sequencer: drives whole layers with random handshakes
// and compares the observed request, pass order and timing against values
// computed from the layer arithmetic.
`timescale 1ns/1ps
module tb_wgt_load_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_oc = '0;
  logic [15:0] cfg_ic = '0;
  logic [7:0]  cfg_kh = '0;
  logic [7:0]  cfg_kw = '0;
  logic [7:0]  cfg_wgt_bits = '0;
  logic        busy, done, err, dma_req_valid, wb_load_start, wb_read_start;
  logic        dma_req_ready = 1'b0;
  logic        wb_load_done = 1'b0;
  logic        rd_valid = 1'b0;
  logic        rd_ready = 1'b0;
  logic [31:0] dma_req_bytes, wb_wgt_bytes;
  logic [2:0]  wb_slice_sel;
  logic [15:0] wb_ic_tile;

  always #5 clk = ~clk;

  wgt_load_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_oc(cfg_oc), .cfg_ic(cfg_ic), .cfg_kh(cfg_kh), .cfg_kw(cfg_kw), .cfg_wgt_bits(cfg_wgt_bits),
    .busy(busy), .done(done), .err(err),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_bytes(dma_req_bytes),
    .wb_load_start(wb_load_start), .wb_wgt_bytes(wb_wgt_bytes), .wb_load_done(wb_load_done),
    .wb_read_start(wb_read_start), .wb_slice_sel(wb_slice_sel), .wb_ic_tile(wb_ic_tile),
    .rd_valid(rd_valid), .rd_ready(rd_ready)
  );

  int checks = 0;
  int errors = 0;

  // Observations collected by run_layer for the test tasks to judge.
  int          ob_err_count, ob_err_cycle, ob_done_count, ob_done_cycle;
  int          ob_dma_cycles, ob_dma_unstable, ob_load_starts, ob_anom, ob_busy_after;
  logic [31:0] ob_dma_bytes, ob_wgt_bytes;
  bit          ob_timeout, ob_rst_zero, ob_rst_done, ob_rst_busy;
  int          ob_slice[$];
  int          ob_tile[$];

  // Layer arithmetic straight from the rules: sizing, legality, pass shape.
  function automatic void model(input int oc, input int ic, input int kh, input int kw, input int bits,
                                output bit ok, output longint bytes, output int slices,
                                output int tiles, output int beats);
    bytes  = (longint'(oc) * ic * kh * kw * bits + 7) / 8;
    ok     = (oc > 0) && (ic > 0) && (kh > 0) && (kw > 0) &&
             (bits == 2 || bits == 4 || bits == 8 || bits == 16) && (bytes <= 8192);
    slices = bits / 2;
    tiles  = (ic + 15) / 16;
    beats  = kh * kw * ((oc + 15) / 16);
  endfunction

  // Drives one layer and records what the DUT did. A pass is expected to end
  // after exp_beats handshakes counted from the cycle after its read_start;
  // the next read_start (or done) must then follow exactly two cycles later.
  task automatic run_layer(input int oc, input int ic, input int kh, input int kw, input int bits,
                           input int exp_beats, input int dma_stall, input int load_delay,
                           input int rd_pct, input bit poke, input int rst_after);
    int dma_wait = 0;
    int load_at = -1;
    int expect_rs = -1;
    int expect_end = -1;
    int fires = 0;
    bit in_read = 0;
    int cur_slice = 0;
    int cur_tile = 0;
    int end_cyc = -1;
    bit stop = 0;
    bit do_rst = 0;
    ob_err_count = 0; ob_err_cycle = -1; ob_done_count = 0; ob_done_cycle = -1;
    ob_dma_cycles = 0; ob_dma_unstable = 0; ob_load_starts = 0; ob_anom = 0; ob_busy_after = -1;
    ob_dma_bytes = '0; ob_wgt_bytes = '0; ob_timeout = 1;
    ob_rst_zero = 0; ob_rst_done = 0; ob_rst_busy = 0;
    ob_slice.delete(); ob_tile.delete();
    for (int cyc = 0; cyc < 8000 && !stop; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) begin
        cfg_oc = 16'(oc); cfg_ic = 16'(ic); cfg_kh = 8'(kh); cfg_kw = 8'(kw); cfg_wgt_bits = 8'(bits);
        start = 1'b1;
      end else begin
        // Config must already be latched, so scramble it.
        cfg_oc = 16'($urandom); cfg_ic = 16'($urandom); cfg_kh = 8'($urandom);
        cfg_kw = 8'($urandom); cfg_wgt_bits = 8'($urandom);
        start = poke && busy && (cyc % 5 == 2);
      end
      rd_valid      = (rd_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < 80);
      rd_ready      = int'($urandom_range(0, 99)) < rd_pct;
      dma_req_ready = dma_req_valid && (dma_wait >= dma_stall);
      wb_load_done  = (cyc == load_at) ||
                      (poke && dma_req_valid && !dma_req_ready && ($urandom_range(0, 1) == 1));
      #1;
      if (err) begin
        ob_err_count++;
        if (ob_err_cycle < 0) ob_err_cycle = cyc;
        if (end_cyc < 0) end_cyc = cyc;
      end
      if (dma_req_valid) begin
        if (ob_dma_cycles == 0) ob_dma_bytes = dma_req_bytes;
        else if (dma_req_bytes !== ob_dma_bytes) ob_dma_unstable++;
        ob_dma_cycles++;
        dma_wait++;
      end
      if (wb_load_start) begin
        ob_load_starts++;
        ob_wgt_bytes = wb_wgt_bytes;
        load_at   = cyc + 1 + load_delay;
        expect_rs = load_at + 1;
        if (!(dma_req_valid && dma_req_ready)) ob_anom++;
      end
      if (wb_read_start) begin
        if (cyc != expect_rs) ob_anom++;
        ob_slice.push_back(int'(wb_slice_sel));
        ob_tile.push_back(int'(wb_ic_tile));
        cur_slice = int'(wb_slice_sel);
        cur_tile  = int'(wb_ic_tile);
        in_read = 1; fires = 0; expect_rs = -1;
      end else if (in_read) begin
        if (int'(wb_slice_sel) != cur_slice || int'(wb_ic_tile) != cur_tile) ob_anom++;
        if (rd_valid && rd_ready) begin
          fires++;
          if (rst_after > 0 && fires == rst_after) do_rst = 1;
          if (fires == exp_beats) begin
            in_read = 0;
            expect_rs = cyc + 2;
            expect_end = cyc + 2;
          end
        end
      end
      if (cyc == expect_end && !wb_read_start && !done) ob_anom++;
      if (done) begin
        ob_done_count++;
        if (ob_done_cycle < 0) ob_done_cycle = cyc;
        if (cyc != expect_end) ob_anom++;
        if (wb_slice_sel !== 3'd0 || wb_ic_tile !== 16'd0) ob_anom++;
        if (wb_wgt_bytes !== ob_wgt_bytes) ob_anom++;
        if (end_cyc < 0) end_cyc = cyc;
      end
      if (end_cyc >= 0 && cyc == end_cyc + 1) ob_busy_after = int'(busy);
      if (end_cyc >= 0 && cyc == end_cyc + 2) begin
        stop = 1; ob_timeout = 0;
      end
      if (do_rst) begin
        #2 rst_n = 1'b0;
        #1;
        ob_rst_zero = ({busy, done, err, dma_req_valid, wb_load_start, wb_read_start,
                        dma_req_bytes, wb_wgt_bytes, wb_slice_sel, wb_ic_tile} === '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #1;
          start = 1'b0;
          #1;
          if (done) ob_rst_done = 1;
          if (busy) ob_rst_busy = 1;
        end
        stop = 1; ob_timeout = 0;
      end
    end
    start = 1'b0; dma_req_ready = 1'b0; wb_load_done = 1'b0; rd_valid = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [88:0] outs;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outs = {busy, done, err, dma_req_valid, wb_load_start, wb_read_start,
            dma_req_bytes, wb_wgt_bytes, wb_slice_sel, wb_ic_tile};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    outs = {busy, done, err, dma_req_valid, wb_load_start, wb_read_start,
            dma_req_bytes, wb_wgt_bytes, wb_slice_sel, wb_ic_tile};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL idle_outputs got %h want 0", outs); end
    $display("reset: outputs idle after release");
  endtask

  task automatic test_directed();
    // oc, ic, kh, kw, bits, bytes, passes, beats per pass
    int tbl[3][8] = '{'{16, 16, 3, 3, 2, 576, 1, 9},
                      '{32, 32, 3, 3, 4, 4608, 4, 18},
                      '{20, 8, 1, 1, 16, 320, 8, 2}};
    bit ok; longint bytes; int slices, tiles, beats, p;
    for (int i = 0; i < 3; i++) begin
      model(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4], ok, bytes, slices, tiles, beats);
      run_layer(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4], tbl[i][7], 0, 0, 100, 0, 0);
      $display("directed %0d: oc=%0d ic=%0d k=%0dx%0d bits=%0d bytes=%0d passes=%0d done@%0d",
               i, tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4], ob_dma_bytes, ob_slice.size(), ob_done_cycle);
      checks++; if (ob_timeout !== 1'b0) begin errors++; $display("FAIL dir_timeout case %0d got 1 want 0", i); end
      checks++; if (ob_err_count != 0) begin errors++; $display("FAIL dir_err case %0d got %0d want 0", i, ob_err_count); end
      checks++; if (ob_done_count != 1) begin errors++; $display("FAIL dir_done_count case %0d got %0d want 1", i, ob_done_count); end
      checks++; if (ob_dma_bytes !== 32'(tbl[i][5])) begin errors++; $display("FAIL dir_dma_bytes case %0d got %0d want %0d", i, ob_dma_bytes, tbl[i][5]); end
      checks++; if (ob_wgt_bytes !== 32'(tbl[i][5])) begin errors++; $display("FAIL dir_wgt_bytes case %0d got %0d want %0d", i, ob_wgt_bytes, tbl[i][5]); end
      checks++; if (ob_dma_cycles != 1) begin errors++; $display("FAIL dir_dma_cycles case %0d got %0d want 1", i, ob_dma_cycles); end
      checks++; if (ob_slice.size() != tbl[i][6]) begin errors++; $display("FAIL dir_passes case %0d got %0d want %0d", i, ob_slice.size(), tbl[i][6]); end
      checks++; if (ob_anom != 0) begin errors++; $display("FAIL dir_timing case %0d got %0d anomalies want 0", i, ob_anom); end
      checks++; if (ob_done_cycle != 4 + tbl[i][6] * (tbl[i][7] + 2)) begin errors++; $display("FAIL dir_latency case %0d got %0d want %0d", i, ob_done_cycle, 4 + tbl[i][6] * (tbl[i][7] + 2)); end
      checks++; if (ob_busy_after != 0) begin errors++; $display("FAIL dir_idle_after case %0d got busy=%0d want 0", i, ob_busy_after); end
      p = 0;
      for (int t = 0; t < tiles; t++) begin
        for (int s = 0; s < slices; s++) begin
          if (p < ob_slice.size()) begin
            checks++;
            if (ob_slice[p] != s || ob_tile[p] != t * 16) begin
              errors++; $display("FAIL dir_pass_order case %0d pass %0d got (%0d,%0d) want (%0d,%0d)", i, p, ob_slice[p], ob_tile[p], s, t * 16);
            end
          end
          p++;
        end
      end
    end
  endtask

  task automatic test_reject();
    int tbl[4][5] = '{'{16, 16, 3, 3, 6}, '{64, 64, 3, 3, 16}, '{0, 16, 3, 3, 8}, '{16, 16, 3, 0, 4}};
    for (int i = 0; i < 4; i++) begin
      run_layer(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4], 1, 0, 0, 100, 0, 0);
      $display("reject %0d: oc=%0d ic=%0d k=%0dx%0d bits=%0d err@%0d", i, tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4], ob_err_cycle);
      checks++; if (ob_timeout !== 1'b0) begin errors++; $display("FAIL rej_timeout case %0d got 1 want 0", i); end
      checks++; if (ob_err_cycle != 2) begin errors++; $display("FAIL rej_err_cycle case %0d got %0d want 2", i, ob_err_cycle); end
      checks++; if (ob_err_count != 1) begin errors++; $display("FAIL rej_err_count case %0d got %0d want 1", i, ob_err_count); end
      checks++; if (ob_dma_cycles != 0) begin errors++; $display("FAIL rej_dma case %0d got %0d want 0", i, ob_dma_cycles); end
      checks++; if (ob_done_count != 0 || ob_load_starts != 0) begin errors++; $display("FAIL rej_activity case %0d got done=%0d load=%0d want 0", i, ob_done_count, ob_load_starts); end
      checks++; if (ob_busy_after != 0) begin errors++; $display("FAIL rej_idle_after case %0d got busy=%0d want 0", i, ob_busy_after); end
    end
  endtask

  task automatic test_backpressure();
    bit ok; longint bytes; int slices, tiles, beats, p;
    model(32, 32, 3, 3, 4, ok, bytes, slices, tiles, beats);
    run_layer(32, 32, 3, 3, 4, beats, 5, 3, 50, 1, 0);
    $display("backpressure: bytes=%0d passes=%0d done@%0d", ob_dma_bytes, ob_slice.size(), ob_done_cycle);
    checks++; if (ob_timeout !== 1'b0) begin errors++; $display("FAIL bp_timeout got 1 want 0"); end
    checks++; if (ob_done_count != 1 || ob_err_count != 0) begin errors++; $display("FAIL bp_done got done=%0d err=%0d want 1/0", ob_done_count, ob_err_count); end
    checks++; if (ob_dma_cycles != 6) begin errors++; $display("FAIL bp_dma_cycles got %0d want 6", ob_dma_cycles); end
    checks++; if (ob_dma_unstable != 0) begin errors++; $display("FAIL bp_dma_stable got %0d changes want 0", ob_dma_unstable); end
    checks++; if (ob_dma_bytes !== 32'(bytes)) begin errors++; $display("FAIL bp_bytes got %0d want %0d", ob_dma_bytes, bytes); end
    checks++; if (ob_load_starts != 1) begin errors++; $display("FAIL bp_load_starts got %0d want 1", ob_load_starts); end
    checks++; if (ob_slice.size() != slices * tiles) begin errors++; $display("FAIL bp_passes got %0d want %0d", ob_slice.size(), slices * tiles); end
    checks++; if (ob_anom != 0) begin errors++; $display("FAIL bp_timing got %0d anomalies want 0", ob_anom); end
    checks++; if (ob_done_cycle < 4 + slices * tiles * (beats + 2) + 5 + 3) begin errors++; $display("FAIL bp_latency got %0d want >= %0d", ob_done_cycle, 4 + slices * tiles * (beats + 2) + 8); end
    p = 0;
    for (int t = 0; t < tiles; t++) begin
      for (int s = 0; s < slices; s++) begin
        if (p < ob_slice.size()) begin
          checks++;
          if (ob_slice[p] != s || ob_tile[p] != t * 16) begin
            errors++; $display("FAIL bp_pass_order pass %0d got (%0d,%0d) want (%0d,%0d)", p, ob_slice[p], ob_tile[p], s, t * 16);
          end
        end
        p++;
      end
    end
  endtask

  task automatic test_random();
    int bits_tbl[12] = '{2, 4, 8, 16, 2, 4, 8, 16, 0, 3, 6, 32};
    int pct_tbl[3] = '{30, 60, 100};
    bit ok; longint bytes; int slices, tiles, beats, p;
    int oc, ic, kh, kw, bits, dstall, ldly, pct;
    for (int i = 0; i < 12; i++) begin
      oc = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 40));
      ic = int'($urandom_range(1, 40));
      kh = int'($urandom_range(1, 3));
      kw = int'($urandom_range(1, 3));
      bits = bits_tbl[$urandom_range(0, 11)];
      dstall = int'($urandom_range(0, 4));
      ldly = int'($urandom_range(0, 3));
      pct = pct_tbl[$urandom_range(0, 2)];
      model(oc, ic, kh, kw, bits, ok, bytes, slices, tiles, beats);
      run_layer(oc, ic, kh, kw, bits, beats, dstall, ldly, pct, $urandom_range(0, 1) == 1, 0);
      $display("random %0d: oc=%0d ic=%0d k=%0dx%0d bits=%0d legal=%0d bytes=%0d passes=%0d end@%0d",
               i, oc, ic, kh, kw, bits, ok, ob_dma_bytes, ob_slice.size(), ok ? ob_done_cycle : ob_err_cycle);
      checks++; if (ob_timeout !== 1'b0) begin errors++; $display("FAIL rnd_timeout case %0d got 1 want 0", i); end
      if (ok) begin
        checks++; if (ob_done_count != 1 || ob_err_count != 0) begin errors++; $display("FAIL rnd_done case %0d got done=%0d err=%0d want 1/0", i, ob_done_count, ob_err_count); end
        checks++; if (ob_dma_bytes !== 32'(bytes)) begin errors++; $display("FAIL rnd_bytes case %0d got %0d want %0d", i, ob_dma_bytes, bytes); end
        checks++; if (ob_dma_cycles != dstall + 1) begin errors++; $display("FAIL rnd_dma_cycles case %0d got %0d want %0d", i, ob_dma_cycles, dstall + 1); end
        checks++; if (ob_slice.size() != slices * tiles) begin errors++; $display("FAIL rnd_passes case %0d got %0d want %0d", i, ob_slice.size(), slices * tiles); end
        checks++; if (ob_anom != 0) begin errors++; $display("FAIL rnd_timing case %0d got %0d anomalies want 0", i, ob_anom); end
        p = 0;
        for (int t = 0; t < tiles; t++) begin
          for (int s = 0; s < slices; s++) begin
            if (p < ob_slice.size()) begin
              checks++;
              if (ob_slice[p] != s || ob_tile[p] != t * 16) begin
                errors++; $display("FAIL rnd_pass_order case %0d pass %0d got (%0d,%0d) want (%0d,%0d)", i, p, ob_slice[p], ob_tile[p], s, t * 16);
              end
            end
            p++;
          end
        end
      end else begin
        checks++; if (ob_err_cycle != 2 || ob_err_count != 1) begin errors++; $display("FAIL rnd_reject case %0d got err@%0d x%0d want @2 x1", i, ob_err_cycle, ob_err_count); end
        checks++; if (ob_dma_cycles != 0 || ob_done_count != 0) begin errors++; $display("FAIL rnd_reject_activity case %0d got dma=%0d done=%0d want 0", i, ob_dma_cycles, ob_done_count); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    run_layer(32, 32, 3, 3, 4, 18, 0, 0, 100, 0, 5);
    $display("reset mid-read: outputs_zero=%0d done_after=%0d busy_after=%0d", ob_rst_zero, ob_rst_done, ob_rst_busy);
    checks++; if (ob_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got 1 want 0"); end
    checks++; if (ob_rst_zero !== 1'b1) begin errors++; $display("FAIL rst_outputs_zero got 0 want 1"); end
    checks++; if (ob_rst_done !== 1'b0 || ob_done_count != 0) begin errors++; $display("FAIL rst_no_done got %0d want 0", ob_rst_done); end
    checks++; if (ob_rst_busy !== 1'b0) begin errors++; $display("FAIL rst_stays_idle got busy=1 want 0"); end
    run_layer(16, 16, 3, 3, 2, 9, 0, 0, 100, 0, 0);
    $display("after reset: bytes=%0d passes=%0d done@%0d", ob_dma_bytes, ob_slice.size(), ob_done_cycle);
    checks++; if (ob_done_count != 1 || ob_anom != 0) begin errors++; $display("FAIL rst_rerun got done=%0d anomalies=%0d want 1/0", ob_done_count, ob_anom); end
    checks++; if (ob_dma_bytes !== 32'd576) begin errors++; $display("FAIL rst_rerun_bytes got %0d want 576", ob_dma_bytes); end
    checks++; if (ob_done_cycle != 15) begin errors++; $display("FAIL rst_rerun_latency got %0d want 15", ob_done_cycle); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reject();
    test_backpressure();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
